// File: rtl/ql_pkg.sv
// Shared constants and scheduler state encoding for the Q-learning traffic blocks.
package ql_pkg;

    localparam int ACTION_W = 2;
    localparam int LANES    = 4;
    localparam int LEVEL_W  = 3;
    localparam int STATE_W  = LANES * LEVEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EP_INIT,
        ST_REQ_A,
        ST_REQ_B,
        ST_STEP,
        ST_SETTLE,
        ST_EP_END,
        ST_DONE
    } sched_state_e;

    function automatic logic is_req_state(input sched_state_e s);
        return (s == ST_REQ_A) || (s == ST_REQ_B);
    endfunction

    function automatic logic is_rest_state(input sched_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/ql_step_scheduler_if.sv
// Control, agent-handshake and environment signals of the step scheduler.
interface ql_step_scheduler_if #(
    parameter int STEP_W = 8,
    parameter int EP_W   = 8
);
    import ql_pkg::*;

    logic                start;
    logic                abort;
    logic [STATE_W-1:0]  S_A;
    logic [STATE_W-1:0]  S_B;
    logic                agent_ack;
    logic [ACTION_W-1:0] agent_action;

    logic                agent_req;
    logic                agent_sel;
    logic [STATE_W-1:0]  agent_state;
    logic [ACTION_W-1:0] A_A;
    logic [ACTION_W-1:0] A_B;
    logic                env_step;
    logic                env_rst;
    logic                ep_done;
    logic [STEP_W-1:0]   step_cnt;
    logic [EP_W-1:0]     ep_cnt;
    logic                busy;
    logic                done;
    logic                timeout_err;

    modport master (
        output start, abort, S_A, S_B, agent_ack, agent_action,
        input  agent_req, agent_sel, agent_state, A_A, A_B, env_step, env_rst,
               ep_done, step_cnt, ep_cnt, busy, done, timeout_err
    );

    modport slave (
        input  start, abort, S_A, S_B, agent_ack, agent_action,
        output agent_req, agent_sel, agent_state, A_A, A_B, env_step, env_rst,
               ep_done, step_cnt, ep_cnt, busy, done, timeout_err
    );

endinterface

// File: rtl/ql_ack_timer.sv
// Wait counter for an agent handshake: restarts at 1 on entry, flags once LIMIT cycles elapsed.
module ql_ack_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_en,
    output logic o_expired
);

    localparam int               CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_count;
    logic             w_expired;

    // The count equals the 1-based cycle index inside the wait, so the flag rises on the LIMIT-th cycle.
    assign w_expired = (r_count >= LIMIT_V);
    assign o_expired = w_expired;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= CNT_W'(1);
        end else if (i_en && !w_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ql_step_scheduler.sv
// Episode sequencer sharing one Q-agent between intersections A and B:
// requests A then B actions, pulses the environment step and tracks step/episode counts.
module ql_step_scheduler
    import ql_pkg::*;
#(
    parameter int MAX_STEPS    = 64,
    parameter int MAX_EPISODES = 16,
    parameter int STEP_W       = 8,
    parameter int EP_W         = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst,
    ql_step_scheduler_if.slave bus
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
    localparam logic [EP_W-1:0]   LAST_EP   = EP_W'(MAX_EPISODES - 1);

    sched_state_e        r_state;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [EP_W-1:0]     r_ep_cnt;
    logic [ACTION_W-1:0] r_a_a;
    logic [ACTION_W-1:0] r_a_b;
    logic                r_timeout_err;

    sched_state_e w_next;
    logic         w_latch_a;
    logic         w_latch_b;
    logic         w_set_err;
    logic         w_clr_run;
    logic         w_clr_step;
    logic         w_inc_step;
    logic         w_inc_ep;
    logic         w_timer_start;
    logic         w_timer_en;
    logic         w_expired;

    ql_ack_timer #(
        .LIMIT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_timer_start),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_next     = r_state;
        w_latch_a  = 1'b0;
        w_latch_b  = 1'b0;
        w_set_err  = 1'b0;
        w_clr_run  = 1'b0;
        w_clr_step = 1'b0;
        w_inc_step = 1'b0;
        w_inc_ep   = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_clr_run = 1'b1;
                    w_next    = ST_EP_INIT;
                end
            end
            ST_EP_INIT: begin
                w_clr_step = 1'b1;
                w_next     = ST_REQ_A;
            end
            // An ack on the expiry cycle wins: the action is taken and no error is flagged.
            ST_REQ_A: begin
                if (bus.agent_ack) begin
                    w_latch_a = 1'b1;
                    w_next    = ST_REQ_B;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_next    = ST_REQ_B;
                end
            end
            ST_REQ_B: begin
                if (bus.agent_ack) begin
                    w_latch_b = 1'b1;
                    w_next    = ST_STEP;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_next    = ST_STEP;
                end
            end
            ST_STEP: begin
                w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_inc_step = 1'b1;
                w_next     = (r_step_cnt == LAST_STEP) ? ST_EP_END : ST_REQ_A;
            end
            ST_EP_END: begin
                w_inc_ep = 1'b1;
                w_next   = (r_ep_cnt == LAST_EP) ? ST_DONE : ST_EP_INIT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Abort freezes counters, actions and the error flag; only the state moves.
        if (bus.abort) begin
            w_next     = ST_IDLE;
            w_latch_a  = 1'b0;
            w_latch_b  = 1'b0;
            w_set_err  = 1'b0;
            w_clr_run  = 1'b0;
            w_clr_step = 1'b0;
            w_inc_step = 1'b0;
            w_inc_ep   = 1'b0;
        end

        w_timer_start = is_req_state(w_next) && (w_next != r_state);
        w_timer_en    = is_req_state(r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt    <= '0;
            r_ep_cnt      <= '0;
            r_a_a         <= '0;
            r_a_b         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_clr_run) begin
                r_step_cnt    <= '0;
                r_ep_cnt      <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_clr_step) begin
                    r_step_cnt <= '0;
                end else if (w_inc_step && (r_step_cnt != '1)) begin
                    r_step_cnt <= r_step_cnt + STEP_W'(1);
                end
                if (w_inc_ep && (r_ep_cnt != '1)) begin
                    r_ep_cnt <= r_ep_cnt + EP_W'(1);
                end
                if (w_set_err) begin
                    r_timeout_err <= 1'b1;
                end
            end
            if (w_latch_a) begin
                r_a_a <= bus.agent_action;
            end
            if (w_latch_b) begin
                r_a_b <= bus.agent_action;
            end
        end
    end

    // Outputs decode the registered state, so each pulse lasts exactly one state-cycle.
    assign bus.agent_req   = is_req_state(r_state);
    assign bus.agent_sel   = (r_state == ST_REQ_B);
    assign bus.agent_state = (r_state == ST_REQ_A) ? bus.S_A :
                             (r_state == ST_REQ_B) ? bus.S_B : '0;
    assign bus.A_A         = r_a_a;
    assign bus.A_B         = r_a_b;
    assign bus.env_step    = (r_state == ST_STEP);
    assign bus.env_rst     = (r_state == ST_EP_INIT);
    assign bus.ep_done     = (r_state == ST_EP_END);
    assign bus.step_cnt    = r_step_cnt;
    assign bus.ep_cnt      = r_ep_cnt;
    assign bus.busy        = !is_rest_state(r_state);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.timeout_err = r_timeout_err;

endmodule
